// File: rtl/memory_seek_ctrl_if.sv
// memory_seek_ctrl_if
//   Request/response bus of the seek sequencer.
//   Request side : req_valid/req_ready handshake carrying the target address req_addr.
//   Response side: rsp_valid/rsp_ready handshake carrying rsp_addr, rsp_data and rsp_err.
//   master modport: the client that issues requests and takes responses.
//   slave modport : the sequencer itself.
interface memory_seek_ctrl_if #(
    parameter int N = 2,
    parameter int M = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_addr;
    logic [M-1:0] rsp_data;
    logic         rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_err
    );
endinterface

// File: rtl/memory_seek_ctrl.sv
// memory_seek_ctrl
//   Drives an up/down-keyed address-counter memory to a requested address along the
//   shortest wrap-around path, then returns the word found there. If the memory does not
//   arrive within MAX_STEPS key pulses, the current address/word are returned with rsp_err.
// Ports
//   clk            : clock, all logic on the rising edge
//   reset          : asynchronous, active-high
//   bus            : request/response handshake bus (slave side)
//   count_up_key   : one-cycle pulse, memory increments its address on the closing edge
//   count_down_key : one-cycle pulse, memory decrements its address on the closing edge
//   mem_address    : memory's current address register
//   mem_data       : memory's word at mem_address (combinational)
//   busy           : sequencer is not idle
module memory_seek_ctrl #(
    parameter int N         = 2,
    parameter int M         = 8,
    parameter int MAX_STEPS = 2 ** N
) (
    input  logic                clk,
    input  logic                reset,
    memory_seek_ctrl_if.slave   bus,
    output logic                count_up_key,
    output logic                count_down_key,
    input  logic [N-1:0]        mem_address,
    input  logic [M-1:0]        mem_data,
    output logic                busy
);
    // Counter must hold MAX_STEPS itself so the budget test never sees a wrapped value.
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);
    // Half the ring: a forward distance equal to this still goes up (tie breaks upward).
    localparam logic [N-1:0] HALF = N'(2 ** (N - 1));

    typedef enum logic [1:0] {IDLE, SEEK, STEP, RESP} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  target_q, target_d;
    logic [SW-1:0] steps_q, steps_d;
    logic          up_q, up_d;
    logic          dn_q, dn_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [N-1:0]  rsp_addr_q, rsp_addr_d;
    logic [M-1:0]  rsp_data_q, rsp_data_d;
    logic [N-1:0]  fwd_dist;

    // Forward distance from the memory's address to the target, modulo 2**N.
    assign fwd_dist = target_q - mem_address;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            steps_q     <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            steps_q     <= steps_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        steps_d     = steps_q;
        // Keys are pulses: low unless SEEK explicitly arms one for the coming STEP cycle.
        up_d        = 1'b0;
        dn_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    target_d = bus.req_addr;
                    steps_d  = '0;
                    state_d  = SEEK;
                end
            end
            SEEK: begin
                if (mem_address == target_q || steps_q == STEP_LIMIT) begin
                    rsp_addr_d  = mem_address;
                    rsp_data_d  = mem_data;
                    rsp_err_d   = (mem_address != target_q);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    if (fwd_dist <= HALF) begin
                        up_d = 1'b1;
                    end else begin
                        dn_d = 1'b1;
                    end
                    steps_d = steps_q + SW'(1);
                    state_d = STEP;
                end
            end
            STEP: begin
                // The memory moves on the edge closing this cycle; re-evaluate afterwards.
                state_d = SEEK;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_data    = rsp_data_q;
    assign count_up_key    = up_q;
    assign count_down_key  = dn_q;
endmodule
